fft_peak_pick: RTL and testbench
================================

# fft_peak_pick

Streaming peak picker that sits directly downstream of the per-bin power stage (|X|² = re² + im²). It consumes one 64-bit power value per FFT bin, detects local maxima over the positive-frequency half of the spectrum, and keeps the two strongest. At frame end it reports their bin indices and powers, which the separation controller uses as the two source frequencies. The block is always ready: no backpressure, one bin per clock at most.

## Interface

Parameters:
- FFT_LEN, 1024 — bins per frame (power of 2).
- IDX_W, 10 — bin index width, log2(FFT_LEN).
- MIN_BIN, 2 — lowest bin eligible as a peak (excludes DC/leakage).

Ports:
- sys_clk  in  1  — single clock; all logic on rising edge.
- sys_rst  in  1  — synchronous, active-high reset.
- power  in  64  — unsigned bin power, aligned with power_valid.
- power_valid  in  1  — power carries a bin this cycle.
- power_last  in  1  — qualifies the final bin of a frame (meaningful only with power_valid).
- peak1_idx  out  IDX_W  — bin of strongest peak.
- peak1_pow  out  64  — its power.
- peak2_idx  out  IDX_W  — bin of second peak.
- peak2_pow  out  64  — its power.
- num_peaks  out  2  — valid peaks found, 0..2.
- result_valid  out  1  — one-cycle pulse, new result on outputs.

## Operation

- Bin counter: cleared to 0 by reset and after each frame end; increments on each power_valid beat. Frame ends on a beat with power_last=1, or on the beat with index FFT_LEN-1, whichever comes first.
- 3-tap window (left, centre, right) shifts on each valid beat. When bin k arrives, bin k-1 is evaluated as centre.
- Candidate rule for centre bin c: MIN_BIN ≤ c ≤ FFT_LEN/2-1, AND P[c] > P[c-1] (strict), AND P[c] ≥ P[c+1]. A plateau therefore yields only its first bin.
- Top-2 update per candidate p: if p > pow1, then slot2 ← slot1 and slot1 ← (c, p); else if p > pow2, then slot2 ← (c, p). Equal powers keep the earlier index ranked higher. The candidate count saturates at 2.
- Frame accumulators are cleared when bin 0 is accepted. Output registers are loaded only at result time, so outputs hold the last result while the next frame streams.
- Unfilled slots report idx 0 and pow 0.
- FSM has three states:
  - IDLE: waits for a valid beat; goes to SCAN.
  - SCAN: on the frame-end beat, goes to FLUSH.
  - FLUSH: performs the last evaluation and update, loads the outputs, and pulses result_valid; goes to SCAN if power_valid is high this cycle, else IDLE.
- A valid beat arriving during FLUSH is bin 0 of the next frame. It is accepted, and the accumulator clear takes effect without corrupting the result being loaded.
- Bins ≥ FFT_LEN/2 are shifted through the window but are never candidates.

## Timing

- Reset values: all outputs 0; FSM in IDLE; counter, window and accumulators 0.
- Evaluation and update of bin k-1 are registered in the cycle after bin k is accepted.
- result_valid rises exactly 2 cycles after the frame-end beat and is high for 1 cycle. The output fields are stable from that cycle until the next result_valid.
- Back-to-back frames at full rate are supported with zero idle cycles.
- Reset asserted mid-frame discards the frame; no result_valid is produced for it.
- Upstream multiplier latency is not compensated here. power_valid and power_last arrive already delay-matched to power.

## Configuration

- PEAK_THRESH_EN defined: adds input port `peak_thresh` (64 bits). A candidate additionally requires P[c] > peak_thresh. A frame with all peaks at or below the threshold reports num_peaks = 0.
- PEAK_THRESH_EN undefined: the port is absent and there is no threshold test.

## Test plan

All scenarios use FFT_LEN=16 and MIN_BIN=1.

- **Two peaks.** Frame of 16 beats, all 10 except bin3=100, bin6=500, bin12=900. Expect result_valid 2 cycles after the last beat, peak1=(6,500), peak2=(3,100), num_peaks=2. Bin 12 is ignored.
- **Plateau and tie.** Bins 4=5=200, bin 9 irrelevant (≥8), bin 2=200, rest 10. Expect peak1=(2,200), peak2=(4,200), num_peaks=2.
- **Flat frame.** All bins 7. Expect num_peaks=0, both idx 0 and pow 0. power_last at bin 10 ends the frame early, and the result pulse follows 2 cycles later.
- **Back-to-back frames.** Two frames with no gap, with different peaks, and a valid beat during FLUSH. Expect two pulses exactly 16 cycles apart, each with the correct frame's peaks and no cross-frame leakage.
- **Reset mid-frame.** Assert sys_rst at bin 5 of a frame containing a peak of 500, then send a clean frame with a single peak (2,50). Expect no pulse for the aborted frame and a result of peak1=(2,50), num_peaks=1.
- **PEAK_THRESH_EN.** peak_thresh=150 applied to the two-peaks frame. Expect peak1=(6,500), peak2=(0,0), num_peaks=1.

Source files
------------

// File: rtl/fft_peak_pick.sv
// fft_peak_pick
//   Streaming peak picker for a per-bin power spectrum. It takes one 64-bit
//   power value per FFT bin and finds local maxima in bins MIN_BIN ..
//   FFT_LEN/2-1. It keeps the two strongest maxima and reports them once per
//   frame. There is no backpressure; the block accepts one bin per clock.
//
//   Optional feature macro: PEAK_THRESH_EN adds the peak_thresh input. A peak
//   must then also be strictly above that threshold.
//
// Ports
//   sys_clk       in   1      single clock, rising edge
//   sys_rst       in   1      synchronous active-high reset
//   power         in   64     unsigned bin power, qualified by power_valid
//   power_valid   in   1      power carries a bin this cycle
//   power_last    in   1      final bin of the frame (with power_valid)
//   peak_thresh   in   64     minimum peak power (PEAK_THRESH_EN only)
//   peak1_idx     out  IDX_W  bin of strongest peak
//   peak1_pow     out  64     its power
//   peak2_idx     out  IDX_W  bin of second peak
//   peak2_pow     out  64     its power
//   num_peaks     out  2      peaks found, 0..2
//   result_valid  out  1      one-cycle pulse, new result on outputs

module fft_peak_pick #(
    parameter int FFT_LEN = 1024,
    parameter int IDX_W   = 10,
    parameter int MIN_BIN = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [63:0]      power,
    input  logic             power_valid,
    input  logic             power_last,
`ifdef PEAK_THRESH_EN
    input  logic [63:0]      peak_thresh,
`endif
    output logic [IDX_W-1:0] peak1_idx,
    output logic [63:0]      peak1_pow,
    output logic [IDX_W-1:0] peak2_idx,
    output logic [63:0]      peak2_pow,
    output logic [1:0]       num_peaks,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [63:0]      pow;
    } slot_t;

    typedef struct packed {
        slot_t      s1;
        slot_t      s2;
        logic [1:0] npk;
    } acc_t;

    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] HALF_MAX = IDX_W'(FFT_LEN / 2 - 1);
    localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_BIN);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;          // index of the next bin to arrive
    logic [63:0]      w_ctr_q, w_ctr_d;      // most recent bin (window centre)
    logic [63:0]      w_lft_q, w_lft_d;      // bin before the centre
    logic [IDX_W-1:0] ctr_idx_q, ctr_idx_d;  // index of the centre bin
    acc_t             acc_q, acc_d;          // running top-2 for current frame
    slot_t            out1_q, out1_d;
    slot_t            out2_q, out2_d;
    logic [1:0]       num_q, num_d;
    logic             rv_q, rv_d;

    logic             beat;
    logic             frame_end;
    acc_t             acc_eval;

    function automatic logic is_cand(input logic [IDX_W-1:0] c,
                                     input logic [63:0]      lft,
                                     input logic [63:0]      ctr,
                                     input logic [63:0]      rgt);
        logic ok;
        ok = (c >= MIN_IDX) && (c <= HALF_MAX) && (ctr > lft) && (ctr >= rgt);
`ifdef PEAK_THRESH_EN
        ok = ok && (ctr > peak_thresh);
`endif
        return ok;
    endfunction

    // Strict compares keep the earlier bin ahead on equal power.
    function automatic acc_t upd(input acc_t             a,
                                 input logic [IDX_W-1:0] c,
                                 input logic [63:0]      p);
        acc_t r;
        r = a;
        if (p > a.s1.pow) begin
            r.s2 = a.s1;
            r.s1 = '{idx: c, pow: p};
        end else if (p > a.s2.pow) begin
            r.s2 = '{idx: c, pow: p};
        end
        if (a.npk != 2'd2) begin
            r.npk = a.npk + 2'd1;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_ctr_d   = w_ctr_q;
        w_lft_d   = w_lft_q;
        ctr_idx_d = ctr_idx_q;
        acc_d     = acc_q;
        out1_d    = out1_q;
        out2_d    = out2_q;
        num_d     = num_q;
        rv_d      = 1'b0;
        acc_eval  = acc_q;

        beat      = power_valid;
        frame_end = power_valid && (power_last || (cnt_q == LAST_BIN));

        // The frame's last bin has no right neighbour, so it is evaluated
        // here against zero. The result is loaded from this combined value.
        // A bin-0 beat in the same cycle clears acc_d below without touching
        // what is loaded into the outputs.
        if (state_q == S_FLUSH) begin
            if (is_cand(ctr_idx_q, w_lft_q, w_ctr_q, '0)) begin
                acc_eval = upd(acc_q, ctr_idx_q, w_ctr_q);
            end
            acc_d  = acc_eval;
            out1_d = acc_eval.s1;
            out2_d = acc_eval.s2;
            num_d  = acc_eval.npk;
            rv_d   = 1'b1;
        end

        if (beat) begin
            if (cnt_q == '0) begin
                acc_d   = '0;
                w_lft_d = '0;
            end else begin
                w_lft_d = w_ctr_q;
                if (is_cand(ctr_idx_q, w_lft_q, w_ctr_q, power)) begin
                    acc_d = upd(acc_q, ctr_idx_q, w_ctr_q);
                end
            end
            w_ctr_d   = power;
            ctr_idx_d = cnt_q;
            cnt_d     = frame_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (beat) begin
                    state_d = frame_end ? S_FLUSH : S_SCAN;
                end
            end
            S_SCAN: begin
                if (frame_end) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (beat) begin
                    state_d = frame_end ? S_FLUSH : S_SCAN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            w_ctr_q   <= '0;
            w_lft_q   <= '0;
            ctr_idx_q <= '0;
            acc_q     <= '0;
            out1_q    <= '0;
            out2_q    <= '0;
            num_q     <= '0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_ctr_q   <= w_ctr_d;
            w_lft_q   <= w_lft_d;
            ctr_idx_q <= ctr_idx_d;
            acc_q     <= acc_d;
            out1_q    <= out1_d;
            out2_q    <= out2_d;
            num_q     <= num_d;
            rv_q      <= rv_d;
        end
    end

    assign peak1_idx    = out1_q.idx;
    assign peak1_pow    = out1_q.pow;
    assign peak2_idx    = out2_q.idx;
    assign peak2_pow    = out2_q.pow;
    assign num_peaks    = num_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_fft_peak_pick.sv
// Testbench for fft_peak_pick with FFT_LEN=16, MIN_BIN=1. Stimulus pushes the
// expected result and its pulse cycle into a queue. A monitor compares every
// result pulse against the queue and checks that the outputs hold in between.
module tb_fft_peak_pick;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [63:0] power;
    logic        power_valid;
    logic        power_last;
`ifdef PEAK_THRESH_EN
    logic [63:0] peak_thresh;
`endif
    logic [3:0]  peak1_idx;
    logic [63:0] peak1_pow;
    logic [3:0]  peak2_idx;
    logic [63:0] peak2_pow;
    logic [1:0]  num_peaks;
    logic        result_valid;

    typedef struct {
        logic [3:0]  i1;
        logic [63:0] p1;
        logic [3:0]  i2;
        logic [63:0] p2;
        logic [1:0]  n;
        logic [63:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        hold;
    logic [63:0] cyc = '0;
    logic [63:0] frm [16];
    int          checks = 0;
    int          errors = 0;

    fft_peak_pick #(.FFT_LEN(16), .IDX_W(4), .MIN_BIN(1)) dut (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .power        (power),
        .power_valid  (power_valid),
        .power_last   (power_last),
`ifdef PEAK_THRESH_EN
        .peak_thresh  (peak_thresh),
`endif
        .peak1_idx    (peak1_idx),
        .peak1_pow    (peak1_pow),
        .peak2_idx    (peak2_idx),
        .peak2_pow    (peak2_pow),
        .num_peaks    (num_peaks),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 64'd1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_fields(input string pfx, input exp_t e);
        chk({pfx, "_peak1_idx"}, 64'(peak1_idx), 64'(e.i1));
        chk({pfx, "_peak1_pow"}, peak1_pow, e.p1);
        chk({pfx, "_peak2_idx"}, 64'(peak2_idx), 64'(e.i2));
        chk({pfx, "_peak2_pow"}, peak2_pow, e.p2);
        chk({pfx, "_num_peaks"}, 64'(num_peaks), 64'(e.n));
    endtask

    // Monitor: sample 1 time unit after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sys_rst) begin
            hold = '{default: '0};
            chk("reset_result_valid", 64'(result_valid), 64'd0);
            chk_fields("reset", hold);
        end else if (result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse got=1 exp=0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk_fields("result", e);
                hold = e;
            end
        end else begin
            chk_fields("hold", hold);
        end
    end

    function automatic exp_t mk(input logic [3:0] i1, input logic [63:0] p1,
                                input logic [3:0] i2, input logic [63:0] p2,
                                input logic [1:0] n);
        exp_t e;
        e.i1 = i1; e.p1 = p1; e.i2 = i2; e.p2 = p2; e.n = n; e.cyc = '0;
        return e;
    endfunction

    task automatic fill(input logic [63:0] v);
        for (int i = 0; i < 16; i++) frm[i] = v;
    endtask

    // Drive nb beats from frm; power_last only when the frame ends early.
    task automatic run_frame(input int nb, input exp_t e);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            power       = frm[i];
            power_valid = 1'b1;
            power_last  = (i == nb - 1) && (nb < 16);
            if (i == nb - 1) begin
                e.cyc = cyc + 64'd2;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        power_valid = 1'b0;
        power_last  = 1'b0;
        power       = '0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hold        = '{default: '0};
        sys_rst     = 1'b1;
        power       = '0;
        power_valid = 1'b0;
        power_last  = 1'b0;
`ifdef PEAK_THRESH_EN
        peak_thresh = '0;
`endif
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        idle(2);

        // Two peaks; bin 12 is above the eligible range.
        fill(64'd10); frm[3] = 64'd100; frm[6] = 64'd500; frm[12] = 64'd900;
        run_frame(16, mk(4'd6, 64'd500, 4'd3, 64'd100, 2'd2));
        idle(3);

        // Plateau at 4..5 yields bin 4 only; tie at 200 keeps bin 2 first.
        fill(64'd10); frm[2] = 64'd200; frm[4] = 64'd200; frm[5] = 64'd200; frm[9] = 64'd300;
        run_frame(16, mk(4'd2, 64'd200, 4'd4, 64'd200, 2'd2));
        idle(3);

        // Flat frame ended early by power_last on bin 10.
        fill(64'd7);
        run_frame(11, mk(4'd0, 64'd0, 4'd0, 64'd0, 2'd0));
        idle(3);

        // Back-to-back frames; frame B bin 0 lands in frame A's flush cycle.
        fill(64'd10); frm[5] = 64'd300;
        run_frame(16, mk(4'd5, 64'd300, 4'd0, 64'd0, 2'd1));
        fill(64'd20); frm[2] = 64'd80; frm[7] = 64'd90;
        run_frame(16, mk(4'd7, 64'd90, 4'd2, 64'd80, 2'd2));
        idle(3);

        // Reset while bin 5 is presented; the partial frame must vanish.
        fill(64'd10); frm[3] = 64'd500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            power       = frm[i];
            power_valid = 1'b1;
            power_last  = 1'b0;
        end
        @(negedge clk);
        power   = 64'd10;
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst     = 1'b0;
        power_valid = 1'b0;
        idle(2);
        fill(64'd10); frm[2] = 64'd50;
        run_frame(16, mk(4'd2, 64'd50, 4'd0, 64'd0, 2'd1));
        idle(3);

`ifdef PEAK_THRESH_EN
        peak_thresh = 64'd150;
        fill(64'd10); frm[3] = 64'd100; frm[6] = 64'd500; frm[12] = 64'd900;
        run_frame(16, mk(4'd6, 64'd500, 4'd0, 64'd0, 2'd1));
        idle(3);
`endif

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("pending_results", 64'(sb_q.size()), 64'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
